grf_wb_sink: RTL and testbench
==============================

Name: grf_wb_sink

Overview:
- General register file at the receiving end of the write-back interface driven by the W pipeline stage (WD_W / addr_W / RegWrite_W, plus the W-stage PC).
- Holds 32x32-bit GPRs and commits one write per cycle.
- Serves two combinational read ports to the D stage, with internal write-to-read bypass.
- Buffers every committed write into a small trace FIFO, drained over a valid/ready handshake by the bench/display logic.

Parameters:
- TRACE_DEPTH, 4, trace FIFO entries (power of two, >=2).
- DROP_W, 16, width of the saturating dropped-trace counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- RegWrite_W  in  1  write enable from W stage.
- addr_W  in  5  destination register index.
- WD_W  in  32  write data.
- pc_W  in  32  PC of the instruction in W, used for trace only.
- A1  in  5  read address, port 1 (rs).
- A2  in  5  read address, port 2 (rt).
- RD1  out  32  read data, port 1.
- RD2  out  32  read data, port 2.
- trace_valid  out  1  FIFO head holds a committed write.
- trace_ready  in  1  consumer accepts the head this cycle.
- trace_pc  out  32  PC of the head entry.
- trace_addr  out  5  register index of the head entry.
- trace_data  out  32  data of the head entry.
- trace_drop  out  DROP_W  count of commits lost because the FIFO was full.

Behaviour:
- Reset (reset==0 at posedge):
  - All 32 registers go to 0.
  - FIFO is emptied; trace_valid=0, trace_drop=0.
  - Any write or push presented in that cycle is ignored.
  - Reset mid-drain discards all pending entries.
- Commit: at posedge with reset==1, RegWrite_W==1 and addr_W!=0, reg[addr_W] <= WD_W.
  - Writes to $0 are discarded and never traced.
  - Register commit is never stalled or blocked by trace state.
- Read: purely combinational.
  - RD1 = 0 if A1==0.
  - Otherwise RD1 = WD_W if (RegWrite_W && addr_W==A1), i.e. write-first bypass.
  - Otherwise RD1 = reg[A1].
  - RD2 follows the same rule on A2.
- Trace push: every commit (per the rule above) pushes {pc_W, addr_W, WD_W} in the same posedge.
- Trace pop: the head is popped at posedge when trace_valid && trace_ready.
  - trace_pc/addr/data present the head entry whenever trace_valid=1.
  - Head fields are 0 when the FIFO is empty.
  - Head fields hold stable while trace_valid && !trace_ready.
- FIFO: circular buffer, read/write pointers wrap modulo TRACE_DEPTH, occupancy count 0..TRACE_DEPTH.
  - trace_valid = (count != 0), registered-state derived with no combinational path from inputs.
  - Push with empty FIFO: the entry becomes visible the next cycle (1-cycle latency commit-to-trace_valid).
  - Push and pop in the same cycle with count in 1..TRACE_DEPTH: both occur and count is unchanged, including when full.
  - Push when full with no pop: the entry is dropped and trace_drop increments.
  - trace_drop saturates at all-ones.
  - Pop when empty is ignored (trace_ready while !trace_valid has no effect).
- Ordering: trace entries emerge in commit order with no duplication.

Test Plan:
- Reset then read all indices: for every A1/A2 in 0..31, RD1/RD2=0; trace_valid=0, trace_drop=0.
- Write $5=0x12345678 at pc 0x3000, trace_ready=0:
  - Same cycle, A1=5 gives RD1=0x12345678 (bypass).
  - Next cycle RD1 is still 0x12345678.
  - trace_valid=1, trace_pc=0x3000, trace_addr=5, trace_data=0x12345678.
- RegWrite_W=1, addr_W=0, WD_W=0xFFFFFFFF: RD1 with A1=0 stays 0 and no trace entry is pushed (trace_valid stays 0).
- Fill and drop with TRACE_DEPTH=4, trace_ready=0:
  - Commit $1..$6 (data 1..6); trace_drop=2 after the 6th commit.
  - Then trace_ready=1 drains addr 1,2,3,4 in order and trace_valid falls.
  - Registers $5=5 and $6=6 are still written.
- Full with simultaneous push and pop: with 4 entries queued, commit $7 while trace_ready=1.
  - Count stays 4 and trace_drop does not change.
  - Drain order is old 2..4, then $7.
- Reset mid-drain: with 3 entries queued and trace_ready toggling, assert reset=0 for 1 cycle.
  - Next cycle trace_valid=0, trace_drop=0, all registers read 0.
  - A write presented during the reset cycle is not committed.

Source files
------------

// File: rtl/grf_wb_sink.sv
// grf_wb_sink: 32x32 register file on the write-back path, with write-first read bypass and a committed-write trace FIFO
module grf_wb_sink #(
  parameter int TRACE_DEPTH = 4,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite_W,
  input  logic [4:0]        addr_W,
  input  logic [31:0]       WD_W,
  input  logic [31:0]       pc_W,
  input  logic [4:0]        A1,
  input  logic [4:0]        A2,
  output logic [31:0]       RD1,
  output logic [31:0]       RD2,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [31:0]       trace_pc,
  output logic [4:0]        trace_addr,
  output logic [31:0]       trace_data,
  output logic [DROP_W-1:0] trace_drop
);
  localparam int PW = $clog2(TRACE_DEPTH);
  localparam int CW = PW + 1;
  logic [31:0] regs [32];
  logic [31:0] f_pc [TRACE_DEPTH];
  logic [4:0] f_addr [TRACE_DEPTH];
  logic [31:0] f_data [TRACE_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic commit, pop, push, full;
  assign commit = RegWrite_W && addr_W != 5'd0;
  assign full = count == CW'(TRACE_DEPTH);
  assign trace_valid = count != '0;
  assign pop = trace_valid && trace_ready;
  // a pop frees the slot for a same-cycle push, so a full FIFO still accepts it
  assign push = commit && (!full || pop);
  assign RD1 = A1 == 5'd0 ? 32'd0 : (RegWrite_W && addr_W == A1) ? WD_W : regs[A1];
  assign RD2 = A2 == 5'd0 ? 32'd0 : (RegWrite_W && addr_W == A2) ? WD_W : regs[A2];
  assign trace_pc = trace_valid ? f_pc[rd_ptr] : 32'd0;
  assign trace_addr = trace_valid ? f_addr[rd_ptr] : 5'd0;
  assign trace_data = trace_valid ? f_data[rd_ptr] : 32'd0;
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      trace_drop <= '0;
    end else begin
      if (commit) regs[addr_W] <= WD_W;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (commit && !push && trace_drop != '1) trace_drop <= trace_drop + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset && push) begin
      f_pc[wr_ptr] <= pc_W;
      f_addr[wr_ptr] <= addr_W;
      f_data[wr_ptr] <= WD_W;
    end
  end
endmodule

// File: tb/tb_grf_wb_sink.sv
// tb_grf_wb_sink: directed test-plan scenarios plus random traffic checked against a queue-based reference model
module tb_grf_wb_sink;
  localparam int D = 4;
  logic clk = 0, reset = 0, RegWrite_W = 0, trace_ready = 0;
  logic [4:0] addr_W = 0, A1 = 0, A2 = 0;
  logic [31:0] WD_W = 0, pc_W = 0;
  logic [31:0] RD1, RD2, trace_pc, trace_data;
  logic [4:0] trace_addr;
  logic trace_valid;
  logic [15:0] trace_drop;
  typedef struct {logic [31:0] pc; logic [4:0] a; logic [31:0] d;} ent_t;
  ent_t q[$];
  logic [31:0] m[32];
  int drop = 0, vectors = 0, errors = 0;

  grf_wb_sink #(.TRACE_DEPTH(D), .DROP_W(16)) dut (
    .clk(clk), .reset(reset), .RegWrite_W(RegWrite_W), .addr_W(addr_W), .WD_W(WD_W), .pc_W(pc_W),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_addr(trace_addr), .trace_data(trace_data), .trace_drop(trace_drop)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mread(logic [4:0] a);
    return a == 0 ? 32'd0 : (RegWrite_W && addr_W == a) ? WD_W : m[a];
  endfunction

  task automatic drive(logic r, logic we, logic [4:0] a, logic [31:0] d, logic [31:0] pc,
                       logic [4:0] ra1, logic [4:0] ra2, logic rdy);
    reset = r; RegWrite_W = we; addr_W = a; WD_W = d; pc_W = pc; A1 = ra1; A2 = ra2; trace_ready = rdy;
  endtask

  task automatic step();
    bit c, p;
    @(negedge clk);
    check("rd1", RD1, mread(A1));
    check("rd2", RD2, mread(A2));
    check("valid", 32'(trace_valid), 32'(q.size() != 0));
    check("t_pc", trace_pc, q.size() ? q[0].pc : 32'd0);
    check("t_addr", 32'(trace_addr), q.size() ? 32'(q[0].a) : 32'd0);
    check("t_data", trace_data, q.size() ? q[0].d : 32'd0);
    check("drop", 32'(trace_drop), 32'(drop));
    @(posedge clk);
    if (!reset) begin
      foreach (m[i]) m[i] = 0;
      q.delete();
      drop = 0;
    end else begin
      c = RegWrite_W && addr_W != 0;
      p = q.size() > 0 && trace_ready;
      if (c) m[addr_W] = WD_W;
      if (p) void'(q.pop_front());
      if (c) begin
        if (q.size() < D) q.push_back('{pc_W, addr_W, WD_W});
        else if (drop < 65535) drop++;
      end
    end
    #1;
  endtask

  initial begin
    foreach (m[i]) m[i] = 0;
    drive(0, 1, 5, 32'hAAAA5555, 0, 0, 0, 0);
    @(posedge clk); #1;
    step();
    for (int i = 0; i < 32; i++) begin
      drive(1, 0, 0, 0, 0, 5'(i), 5'(31 - i), 0);
      step();
    end
    drive(1, 1, 5, 32'h12345678, 32'h3000, 5, 0, 0);
    #1 check("bypass_same_cycle", RD1, 32'h12345678);
    step();
    drive(1, 0, 0, 0, 0, 5, 0, 0);
    #1 check("rd1_after_write", RD1, 32'h12345678);
    check("trace_valid_5", 32'(trace_valid), 1);
    check("trace_pc_5", trace_pc, 32'h3000);
    check("trace_addr_5", 32'(trace_addr), 5);
    check("trace_data_5", trace_data, 32'h12345678);
    step();
    drive(1, 0, 0, 0, 0, 5, 0, 1);
    step();
    drive(1, 1, 0, 32'hFFFFFFFF, 32'h3004, 0, 0, 0);
    #1 check("rd1_zero_reg", RD1, 0);
    step();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #1 check("no_trace_r0", 32'(trace_valid), 0);
    for (int i = 1; i <= 6; i++) begin
      drive(1, 1, 5'(i), 32'(i), 32'h100 + 32'(4 * i), 5'(i), 0, 0);
      step();
    end
    drive(1, 0, 0, 0, 0, 5, 6, 1);
    #1 check("drop_after_fill", 32'(trace_drop), 2);
    check("reg5", RD1, 5);
    check("reg6", RD2, 6);
    for (int k = 1; k <= 4; k++) begin
      check("drain_order", 32'(trace_addr), 32'(k));
      step();
    end
    check("drained_valid", 32'(trace_valid), 0);
    for (int i = 1; i <= 4; i++) begin
      drive(1, 1, 5'(i), 32'h10 + 32'(i), 32'h200 + 32'(4 * i), 0, 0, 0);
      step();
    end
    drive(1, 1, 7, 32'h77, 32'h300, 7, 0, 1);
    step();
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    #1 check("drop_full_pushpop", 32'(trace_drop), 2);
    for (int k = 0; k < 4; k++) begin
      check("full_drain_order", 32'(trace_addr), k < 3 ? 32'(k + 2) : 32'd7);
      step();
    end
    check("full_drained", 32'(trace_valid), 0);
    for (int i = 1; i <= 3; i++) begin
      drive(1, 1, 5'(i + 10), 32'h20 + 32'(i), 32'h400 + 32'(4 * i), 0, 0, 0);
      step();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 1); step();
    drive(1, 0, 0, 0, 0, 0, 0, 0); step();
    drive(0, 1, 9, 32'hDEAD, 32'h500, 0, 0, 1); step();
    drive(1, 0, 0, 0, 0, 9, 11, 0);
    #1 check("rst_valid", 32'(trace_valid), 0);
    check("rst_drop", 32'(trace_drop), 0);
    check("rst_no_commit", RD1, 0);
    check("rst_reg11", RD2, 0);
    for (int i = 0; i < 32; i++) begin
      drive(1, 0, 0, 0, 0, 5'(i), 5'(31 - i), 1);
      step();
    end
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] a;
      a = 5'($urandom_range(0, 31));
      drive($urandom_range(0, 49) != 0, $urandom_range(0, 9) < 7, a, $urandom, $urandom,
            $urandom_range(0, 3) == 0 ? a : 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            $urandom_range(0, 2) == 0);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
